// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for alu_exec_stage: upstream beat (ctrl, operands, tag) and EX/MEM output beat.
// master = producer/consumer side driving inputs; slave = the execute stage.
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [TAG_W-1:0] rd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [TAG_W-1:0] rd_out;
  logic             illegal_op;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, illegal_op
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out, illegal_op
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a 2-entry skid buffer (OUT + SKID) and a saturating illegal-op counter.
// Optional macro ALU_EXEC_SLT_EN adds SLT (0111) and SLTU (1000) as legal codes.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned ERR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  alu_exec_stage_if.slave  bus,
  output logic [ERR_W-1:0] o_err_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [TAG_W-1:0] rd;
    logic             illegal;
  } beat_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           r_state, w_state_d;
  beat_t            r_out, r_skid, w_beat;
  logic             r_in_ready;
  logic [ERR_W-1:0] r_err;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
  logic             w_accept, w_deliver;
  logic             w_load_out, w_load_skid, w_skid_to_out;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (bus.alu_ctrl)
      4'b0010: w_result = bus.op_a + bus.op_b;
      4'b0110: w_result = bus.op_a - bus.op_b;
      4'b0000: w_result = bus.op_a & bus.op_b;
      4'b0001: w_result = bus.op_a | bus.op_b;
      4'b1100: w_result = bus.op_a ^ bus.op_b;
`ifdef ALU_EXEC_SLT_EN
      4'b0111: w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      4'b1000: w_result = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_beat    = {w_result, (w_result == '0), bus.rd_in, w_illegal};
  // A beat offered during flush is dropped even though in_ready may be high.
  assign w_accept  = bus.in_valid & r_in_ready & ~i_flush;
  assign w_deliver = bus.out_valid & bus.out_ready;

  always_comb begin
    w_state_d     = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_load_out = 1'b1;
          w_state_d  = StOne;
        end
      end
      StOne: begin
        if (w_accept && w_deliver) begin
          w_load_out = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_d   = StFull;
        end else if (w_deliver) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        if (w_deliver) begin
          w_skid_to_out = 1'b1;
          w_state_d     = StOne;
        end
      end
      default: w_state_d = StEmpty;
    endcase
    if (i_flush) begin
      w_state_d     = StEmpty;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StEmpty;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skid     <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_d;
      // Registered so in_ready never depends combinationally on out_ready.
      r_in_ready <= (w_state_d != StFull);
      if (w_load_out) begin
        r_out <= w_beat;
      end else if (w_skid_to_out) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_beat;
      end
      if (w_accept && w_illegal && (r_err != {ERR_W{1'b1}})) begin
        r_err <= r_err + ERR_W'(1);
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = (r_state != StEmpty);
  assign bus.result     = r_out.result;
  assign bus.zero       = r_out.zero;
  assign bus.rd_out     = r_out.rd;
  assign bus.illegal_op = r_out.illegal;
  assign o_err_count    = r_err;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU sitting directly downstream of the ALU control decoder. Consumes its 4-bit ALU control code plus two operands, and computes the result and zero flag.
- Registers the result, zero flag and destination tag into an EX/MEM-facing output.
- Uses a valid/ready handshake with a 2-entry skid buffer so that backpressure from MEM never drops a beat.
- Counts illegal-operation beats for debug.

Parameters:
- WIDTH, 32, operand/result width in bits.
- TAG_W, 5, destination-register tag width.
- ERR_W, 8, width of saturating illegal-op counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; clears buffered beats.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- alu_ctrl  input  4  ALU control code from decoder.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- rd_in  input  TAG_W  destination tag, passed through.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- result  output  WIDTH  ALU result.
- zero  output  1  result == 0.
- rd_out  output  TAG_W  tag of output beat.
- illegal_op  output  1  output beat carried an unsupported code.
- err_count  output  ERR_W  saturating count of accepted illegal beats.

Behaviour:
- Handshake rules:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - Payload is computed combinationally from the inputs at accept and captured on that edge.
- Opcode decode:
  - 0010 ADD: a+b, modulo 2^WIDTH, carry discarded.
  - 0110 SUB: a-b, two's complement, modulo 2^WIDTH.
  - 0000 AND, 0001 OR, 1100 XOR: bitwise.
  - Any other code (incl. 1111): result=0, zero=1, illegal_op=1.
- zero is computed from the captured result.
- Storage: output register (OUT) plus skid register (SKID), each holding {result, zero, rd, illegal}.
- State machine: EMPTY, ONE, FULL.
  - EMPTY: out_valid=0, in_ready=1. Accept -> load OUT, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept & deliver -> load OUT, stay ONE.
    - Accept & !deliver -> load SKID, go to FULL.
    - !accept & deliver -> go to EMPTY.
    - Otherwise hold.
  - FULL: out_valid=1, in_ready=0.
    - Deliver -> OUT<=SKID, go to ONE.
    - Otherwise hold.
- in_ready is a registered decode of state (1 unless FULL); it has no combinational path from out_ready.
- Latency: accepted beat appears on out_valid the next cycle when the stage was EMPTY, or when ONE with a simultaneous deliver. Throughput is 1 beat/cycle with out_ready held high.
- OUT contents are stable while out_valid=1 and out_ready=0.
- Reset, when rst=1, overrides everything:
  - state=EMPTY.
  - out_valid=0, in_ready=1 (from next cycle).
  - result=0, zero=0, rd_out=0, illegal_op=0, err_count=0.
  - Reset mid-operation discards both buffered beats.
- Flush, when rst=0 and flush=1:
  - state=EMPTY; OUT/SKID data are don't-care but outputs read out_valid=0.
  - Any beat presented that cycle is dropped even if in_ready=1.
  - err_count is not affected, and an illegal beat offered during flush is not counted.
- err_count:
  - Increments by 1 on each accepted illegal beat (not flushed).
  - Saturates at 2^ERR_W-1; it does not wrap.
- The MEM stage is the sole out_ready source; out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: ALU_EXEC_SLT_EN.
- Defined: code 0111 = SLT (signed a<b ? 1 : 0, zero-extended), and code 1000 = SLTU (unsigned compare). Both are legal: illegal_op=0 and they are not counted.
- Undefined: 0111 and 1000 are illegal, with result=0, zero=1, illegal_op=1, and err_count increments.
- Handshake and latency are identical in both builds.

Test Plan:
- ADD/back-to-back: rst 2 cycles, then out_ready=1 and stream {0010, 5, 7}, {0110, 7, 7}, {1100, F0F0_F0F0, FFFF_FFFF} -> one cycle later each: result 12/zero 0, result 0/zero 1, result 0F0F_0F0F; out_valid high 3 consecutive cycles.
- Backpressure: out_ready=0, offer 3 beats -> first 2 accepted (OUT, SKID), in_ready=0 on 3rd. Then out_ready=1 -> beats emerge in order, OUT stable while stalled, no loss or duplication.
- Wrap-around: ADD FFFF_FFFF+1 -> result 0, zero 1. SUB 0-1 -> FFFF_FFFF, zero 0.
- Illegal/saturation: 300 accepted beats with code 1111 (ERR_W=8) -> each result 0, illegal_op 1, and err_count stops at 255.
- Flush/reset mid-operation: FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, err_count unchanged. Repeat with rst -> all outputs 0.
- With ALU_EXEC_SLT_EN: 0111 a=FFFF_FFFF b=1 -> result 1. 1000 same operands -> result 0, zero 1, illegal_op 0. Without the macro, the same stimulus gives illegal_op 1.
